out_fifo: RTL and testbench

- Receive-side (OUT endpoint) buffer: accepts bytes of host-to-device OUT packets from the USB device core and presents them to the application through a valid/ready stream.
- A packet is stored tentatively and becomes visible to the application only after error-free completion; otherwise it is rolled back.
- Issues NAK when there is no room for a maximum-size packet.
- Single clock domain; the USB-side strobes are qualified by clk_gate_i.

---
 rtl/out_fifo.sv | 147 ++++++++++++++
 tb/tb_out_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_fifo.sv
// out_fifo: OUT-endpoint receive buffer. It holds each packet tentatively, then commits it
//   on a clean end of packet or rolls it back on an error or overflow.
// Latency: a committed byte appears at app_out_valid_o right after the commit edge. It can
//   be popped on the next edge.
// Backpressure: the application stalls with app_out_ready_i. The USB side is NAKed when a
//   maximum-size packet would not fit.
// Ports: clk_i/rstn_i are the clock and async active-low reset. clk_gate_i qualifies the
//   out_* strobes. out_req_i, out_data_i, out_valid_i, out_ready_i and out_err_i come from
//   the USB device core. out_nak_o is the NAK response. app_out_* is the valid/ready byte
//   stream to the application.
// Optional: `define OUT_FIFO_LEVEL_EN adds app_out_level_o, the committed byte count.
module out_fifo #(
  parameter int OUT_MAXPACKETSIZE = 8,
  parameter int BUFFER_DEPTH      = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clk_gate_i,
  input  logic       out_req_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  input  logic       out_ready_i,
  input  logic       out_err_i,
  output logic       out_nak_o,
  output logic [7:0] app_out_data_o,
  output logic       app_out_valid_o,
`ifdef OUT_FIFO_LEVEL_EN
  output logic [$clog2(BUFFER_DEPTH):0] app_out_level_o,
`endif
  input  logic       app_out_ready_i
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_NAK} state_t;

  state_t        state;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;      // end of committed data
  logic [PW-1:0] wr_ptr_tmp;  // end of the packet being received
  logic          overflow;
  logic [7:0]    mem [BUFFER_DEPTH];

  logic [PW-1:0] pkt_len;
  logic [PW-1:0] committed;
  logic [PW:0]   free_space;
  logic          free_ok;
  logic          recv_evt;
  logic          room;
  logic          wr_en;
  logic          drop;
  logic [PW-1:0] tmp_after;
  logic          ovf_after;
  logic          commit;
  logic          pop;
  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;

  assign pkt_len   = wr_ptr_tmp - wr_ptr;
  assign committed = wr_ptr - rd_ptr;

  // A NAK decision is made only in IDLE or NAK, or in RECV right after an abort rollback.
  // In each of those cases wr_ptr_tmp equals wr_ptr, so the free space is measured against
  // the committed data. The rd_ptr used is the pre-edge value, so a same-cycle pop does not
  // count towards the free space.
  assign free_space = (PW+1)'(BUFFER_DEPTH) - {1'b0, committed};
  assign free_ok    = free_space >= (PW+1)'(OUT_MAXPACKETSIZE);

  // A new out_req_i in RECV aborts the current packet and masks the data/end strobes.
  assign recv_evt  = clk_gate_i && (state == ST_RECV) && !out_req_i;
  assign room      = pkt_len < PW'(OUT_MAXPACKETSIZE);
  assign wr_en     = recv_evt && out_valid_i && room;
  assign drop      = recv_evt && out_valid_i && !room;
  assign tmp_after = wr_ptr_tmp + {{AW{1'b0}}, wr_en};
  assign ovf_after = overflow | drop;
  assign commit    = recv_evt && out_ready_i && !out_err_i && !ovf_after;

  assign app_out_valid_o = (rd_ptr != wr_ptr);
  assign app_out_data_o  = app_out_valid_o ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign pop             = app_out_valid_o && app_out_ready_i;

  assign wr_ptr_n = commit ? tmp_after : wr_ptr;
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_tmp[AW-1:0]] <= out_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      wr_ptr_tmp <= '0;
      overflow   <= 1'b0;
      out_nak_o  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      if (clk_gate_i) begin
        case (state)
          ST_IDLE: begin
            if (out_req_i) begin
              state     <= free_ok ? ST_RECV : ST_NAK;
              out_nak_o <= !free_ok;
            end
          end
          ST_RECV: begin
            if (out_req_i) begin
              // Aborted packet: discard it and evaluate the new request.
              wr_ptr_tmp <= wr_ptr;
              overflow   <= 1'b0;
              state      <= free_ok ? ST_RECV : ST_NAK;
              out_nak_o  <= !free_ok;
            end else if (out_ready_i) begin
              wr_ptr_tmp <= commit ? tmp_after : wr_ptr;
              overflow   <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              wr_ptr_tmp <= tmp_after;
              overflow   <= ovf_after;
            end
          end
          ST_NAK: begin
            if (out_req_i) begin
              state     <= free_ok ? ST_RECV : ST_NAK;
              out_nak_o <= !free_ok;
            end else if (out_ready_i) begin
              state     <= ST_IDLE;
              out_nak_o <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef OUT_FIFO_LEVEL_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) app_out_level_o <= '0;
    else         app_out_level_o <= wr_ptr_n - rd_ptr_n;
  end
`endif

endmodule

// File: tb/tb_out_fifo.sv
// tb_out_fifo: directed packet scenarios followed by randomized traffic. All of it is
//   compared every cycle against a queue-based packet model.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: app_out_ready_i is driven from the scenarios and at random.
module tb_out_fifo;

  localparam int MPS = 8;
  localparam int BD  = 16;
  localparam int PW  = $clog2(BD) + 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       gate = 1'b0, req = 1'b0, vld = 1'b0, eop = 1'b0, err = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       nak;
  logic [7:0] app_dat;
  logic       app_vld;
  logic       app_rdy = 1'b0;
`ifdef OUT_FIFO_LEVEL_EN
  logic [PW-1:0] level;
`endif

  always #5 clk = ~clk;

  out_fifo #(.OUT_MAXPACKETSIZE(MPS), .BUFFER_DEPTH(BD)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_gate_i(gate), .out_req_i(req),
    .out_data_i(dat), .out_valid_i(vld), .out_ready_i(eop), .out_err_i(err),
    .out_nak_o(nak), .app_out_data_o(app_dat), .app_out_valid_o(app_vld),
`ifdef OUT_FIFO_LEVEL_EN
    .app_out_level_o(level),
`endif
    .app_out_ready_i(app_rdy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: committed bytes, the packet in flight, and the transaction mode.
  byte unsigned fifo_q[$];
  byte unsigned pkt_q[$];
  int           mode;   // 0 idle, 1 receiving, 2 NAKing
  bit           m_nak;
  bit           m_ovf;

  task automatic model_reset();
    fifo_q.delete(); pkt_q.delete();
    mode = 0; m_nak = 0; m_ovf = 0;
  endtask

  task automatic model_decide();
    pkt_q.delete();
    m_ovf = 0;
    if (BD - fifo_q.size() >= MPS) begin mode = 1; m_nak = 0; end
    else begin mode = 2; m_nak = 1; end
  endtask

  task automatic model_edge();
    bit do_pop;
    do_pop = (fifo_q.size() != 0) && app_rdy;
    if (gate) begin
      if (req) model_decide();
      else if (mode == 1) begin
        if (vld) begin
          if (pkt_q.size() < MPS) pkt_q.push_back(dat);
          else m_ovf = 1;
        end
        if (eop) begin
          if (!err && !m_ovf) foreach (pkt_q[i]) fifo_q.push_back(pkt_q[i]);
          pkt_q.delete();
          m_ovf = 0;
          mode = 0;
        end
      end else if (mode == 2 && eop) begin
        mode = 0; m_nak = 0;
      end
    end
    if (do_pop) void'(fifo_q.pop_front());
  endtask

  task automatic check_outs(input string tag);
    logic [7:0] exp_dat;
    exp_dat = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    check({tag, "_vld"}, app_vld, fifo_q.size() != 0);
    check({tag, "_dat"}, app_dat, exp_dat);
    check({tag, "_nak"}, nak, m_nak);
`ifdef OUT_FIFO_LEVEL_EN
    check({tag, "_lvl"}, level, fifo_q.size());
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic usb(input logic g, input logic r, input logic v, input logic [7:0] d,
                     input logic e, input logic x, input string tag);
    gate = g; req = r; vld = v; dat = d; eop = e; err = x;
    cycle(tag);
    gate = 1'b0; req = 1'b0; vld = 1'b0; eop = 1'b0; err = 1'b0;
  endtask

  // Sends a request, the bytes, and an end of packet, either with the last byte or alone.
  task automatic send_pkt(input byte unsigned d[$], input logic x, input bit joined, input string tag);
    usb(1, 1, 0, 8'h00, 0, 0, tag);
    foreach (d[i]) begin
      if (joined && i == d.size() - 1) usb(1, 0, 1, d[i], 1, x, tag);
      else                             usb(1, 0, 1, d[i], 0, 0, tag);
    end
    if (!joined || d.size() == 0) usb(1, 0, 0, 8'h00, 1, x, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    model_reset();
    #1 check_outs(tag);
    @(negedge clk) rstn = 1'b1;
  endtask

  initial begin
    byte unsigned p[$];
    model_reset();
    #12;
    check_outs("reset");
    @(negedge clk) rstn = 1'b1;

    // 1: one clean 8-byte packet, read after the commit.
    p = '{8'h87, 8'h65, 8'h43, 8'h21, 8'h87, 8'h65, 8'h43, 8'h21};
    send_pkt(p, 0, 0, "t1_rx");
    check("t1_nak", nak, 1'b0);
    app_rdy = 1'b1;
    idle(10, "t1_rd");
    check("t1_empty", app_vld, 1'b0);

    // 2: errored packet leaves nothing behind, then a good packet follows.
    app_rdy = 1'b0;
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(p, 1, 0, "t2_err");
    idle(3, "t2_gap");
    p = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(p, 0, 0, "t2_good");
    app_rdy = 1'b1;
    idle(5, "t2_rd");

    // 3: fill the buffer, get NAKed, drain half, then get accepted.
    app_rdy = 1'b0;
    p = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    send_pkt(p, 0, 0, "t3_a");
    p = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    send_pkt(p, 0, 0, "t3_b");
    p = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    send_pkt(p, 0, 0, "t3_nak");
    check("t3_full_vld", app_vld, 1'b1);
    app_rdy = 1'b1;
    idle(8, "t3_pop");
    app_rdy = 1'b0;
    usb(1, 1, 0, 8'h00, 0, 0, "t3_req");
    check("t3_accept", nak, 1'b0);
    foreach (p[i]) usb(1, 0, 1, p[i], i == 7, 0, "t3_c");
    app_rdy = 1'b1;
    idle(18, "t3_rd");

    // 4: oversize packet is rolled back.
    app_rdy = 1'b0;
    p = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    send_pkt(p, 0, 0, "t4_ovf");
    idle(2, "t4_gap");
    check("t4_empty", app_vld, 1'b0);

    // 5: last byte together with end of packet, while the application is always ready.
    app_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      p.delete();
      for (int i = 0; i < k; i++) p.push_back(8'($urandom));
      send_pkt(p, 0, 1, "t5_join");
    end
    idle(3, "t5_rd");

    // 6: reset in the middle of a packet.
    app_rdy = 1'b0;
    usb(1, 1, 0, 8'h00, 0, 0, "t6_req");
    for (int i = 0; i < 4; i++) usb(1, 0, 1, 8'(8'h50 + i), 0, 0, "t6_rx");
    async_reset("t6_rst");
    p = '{8'h5A, 8'hA5};
    send_pkt(p, 0, 0, "t6_post");
    app_rdy = 1'b1;
    idle(4, "t6_rd");

    // Randomized traffic: gating, aborts, errors, overflows and backpressure.
    for (int c = 0; c < 4000; c++) begin
      app_rdy = ($urandom_range(0, 99) < 45);
      usb($urandom_range(0, 99) < 75,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 50,
          8'($urandom),
          $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 20,
          "rnd");
    end
    app_rdy = 1'b1;
    idle(2 * BD, "drain");
    check("final_empty", app_vld, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
